data_cache: RTL

Direct-mapped, write-back data cache for the 8-bit processor. It sits directly downstream of the ALU: the ALU `RESULT` drives `ADDRESS` for load/store instructions. The cache serves byte reads and writes from the CPU, stalls the CPU through `BUSYWAIT` on a miss, and exchanges 32-bit blocks with data memory through a busy-wait handshake.

---
 rtl/data_cache.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back data cache between the 8-bit CPU and a 32-bit block memory.
// A miss stalls the CPU through BUSYWAIT while an optional write-back and a line fill run.
module data_cache #(
    parameter int BLOCKS = 8,
    parameter int TAGW   = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT,
    output logic [1:0]  o_dbg_state
);
    localparam int IW = $clog2(BLOCKS);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WRITE_BACK = 2'd1,
        S_MEM_FETCH  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BLOCKS-1:0] r_valid;
    logic [BLOCKS-1:0] r_dirty;
    logic [TAGW-1:0]   r_tag [BLOCKS];
    logic [31:0]       r_data [BLOCKS];
    logic              r_mem_read;
    logic              r_mem_write;
    logic [5:0]        r_mem_address;
    logic [31:0]       r_mem_writedata;

    logic [TAGW-1:0]   w_tag;
    logic [IW-1:0]     w_index;
    logic [1:0]        w_offset;
    logic [31:0]       w_line;
    logic              w_hit;
    logic              w_access;
    logic              w_fill_done;

    assign w_tag       = ADDRESS[7 -: TAGW];
    assign w_index     = ADDRESS[2 +: IW];
    assign w_offset    = ADDRESS[1:0];
    assign w_line      = r_data[w_index];
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_access    = READ || WRITE;
    assign w_fill_done = (r_state == S_MEM_FETCH) && !MEM_BUSYWAIT;

    // Handshakes: the CPU holds READ/WRITE/ADDRESS/WRITEDATA until it sees BUSYWAIT low,
    // and the access completes at that posedge. A memory request (MEM_READ or MEM_WRITE)
    // stays up until the first posedge with MEM_BUSYWAIT low, which completes the transfer.
    assign BUSYWAIT    = !RESET && w_access && !((r_state == S_IDLE) && w_hit);
    assign READDATA    = RESET ? 8'h00 : w_line[{w_offset, 3'b000} +: 8];

    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_address;
    assign MEM_WRITEDATA = r_mem_writedata;
    assign o_dbg_state   = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access && !w_hit)
                    w_next = (r_valid[w_index] && r_dirty[w_index]) ? S_WRITE_BACK : S_MEM_FETCH;
            end
            S_WRITE_BACK: begin
                if (!MEM_BUSYWAIT)
                    w_next = S_MEM_FETCH;
            end
            S_MEM_FETCH: begin
                if (!MEM_BUSYWAIT)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Memory request outputs are registered from the next state so they only move on a posedge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state         <= S_IDLE;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_address   <= 6'h00;
            r_mem_writedata <= 32'h0;
        end else begin
            r_state         <= w_next;
            r_mem_read      <= (w_next == S_MEM_FETCH);
            r_mem_write     <= (w_next == S_WRITE_BACK);
            r_mem_address   <= 6'h00;
            r_mem_writedata <= 32'h0;
            if (w_next == S_WRITE_BACK) begin
                r_mem_address   <= {r_tag[w_index], w_index};
                r_mem_writedata <= w_line;
            end else if (w_next == S_MEM_FETCH) begin
                r_mem_address   <= {w_tag, w_index};
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
            for (int i = 0; i < BLOCKS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= 32'h0;
            end
        end else if ((r_state == S_IDLE) && WRITE && w_hit) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
            r_dirty[w_index]                         <= 1'b1;
        end else if (w_fill_done) begin
            r_data[w_index]  <= MEM_READDATA;
            r_tag[w_index]   <= w_tag;
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end
    end
endmodule
